// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the MIPS fetch stage and the
//                main control decoder (sequencer states, marker words,
//                opcode values, branch-offset helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   // End-of-program marker and the word presented when no instruction is live
   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

   // Opcode field values shared with the decoder
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   // Sign-extended 16-bit immediate scaled to a byte offset (imm << 2)
   function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
      return {{14{imm16[15]}}, imm16, 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit_if
//  Description : Load / control / instruction bus of the fetch stage.
//                master = loader and decoder side, slave = fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
   parameter int ADDR_W = 6
);
   logic              load_en;
   logic [ADDR_W-1:0] load_addr;
   logic [31:0]       load_data;
   logic              start;
   logic              branch;
   logic              zero;
   logic [31:0]       instr;
   logic [5:0]        opcode;
   logic [31:0]       pc;
   logic [31:0]       pc_plus4;
   logic              running;
   logic              halted;
   logic [31:0]       instr_count;

   modport master (
      output load_en, load_addr, load_data, start, branch, zero,
      input  instr, opcode, pc, pc_plus4, running, halted, instr_count
   );

   modport slave (
      input  load_en, load_addr, load_data, start, branch, zero,
      output instr, opcode, pc, pc_plus4, running, halted, instr_count
   );
endinterface
`default_nettype wire

// File: rtl/instr_mem.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem
//  Description : Instruction memory, synchronous write port, asynchronous
//                read port. Contents are not cleared by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [31:0]       wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem_q [DEPTH];

   // Write port: the new word is visible to the read port from the next cycle
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Fetch stage of the single-cycle MIPS core. Holds the PC and
//                a loadable instruction memory, computes next-PC from
//                Branch/zero and sequences LOAD -> RUN -> HALT.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int          IMEM_DEPTH = 64,
   parameter int          ADDR_W     = 6,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           reset,
   instr_fetch_unit_if.slave bus
);

   fetch_state_e state_q;
   logic [31:0]  pc_q;
   logic [31:0]  pc_d;
   logic [31:0]  count_q;
   logic [31:0]  count_d;
   logic         running_q;
   logic         halted_q;

   logic         mem_we;
   logic [31:0]  mem_rdata;
   logic         in_range;
   logic [31:0]  fetched;
   logic         halt_hit;
   logic [31:0]  pc_plus4;
   logic [31:0]  btarget;
   logic         pcsrc;

   // Memory accepts writes only while the sequencer is in LOAD
   assign mem_we = bus.load_en && (state_q == ST_LOAD);

   instr_mem #(
      .DEPTH  (IMEM_DEPTH),
      .ADDR_W (ADDR_W)
   ) u_instr_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (bus.load_addr),
      .wdata_i (bus.load_data),
      .raddr_i (pc_q[ADDR_W+1:2]),
      .rdata_o (mem_rdata)
   );

   // A PC past the end of memory fetches nothing and ends the program
   assign in_range = (pc_q[31:ADDR_W+2] == '0);
   assign fetched  = in_range ? mem_rdata : NOP_WORD;
   assign halt_hit = !in_range || (fetched == HALT_WORD);

   // Next-PC: sequential or PC-relative branch, all sums wrap at 32 bits
   assign pc_plus4 = pc_q + 32'd4;
   assign btarget  = pc_plus4 + branch_offset(fetched[15:0]);
   assign pcsrc    = bus.branch & bus.zero;
   assign pc_d     = pcsrc ? btarget : pc_plus4;

   // Retired-instruction counter sticks at all-ones instead of wrapping
   assign count_d  = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;

   // Sequencer: PC, counter and status flags all change only here
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_LOAD;
         pc_q      <= RESET_PC;
         count_q   <= '0;
         running_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         unique case (state_q)
            ST_LOAD: begin
               if (bus.start) begin
                  state_q   <= ST_RUN;
                  pc_q      <= RESET_PC;
                  count_q   <= '0;
                  running_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (halt_hit) begin
                  // Halting instruction is neither executed nor counted
                  state_q   <= ST_HALT;
                  running_q <= 1'b0;
                  halted_q  <= 1'b1;
               end else begin
                  pc_q    <= pc_d;
                  count_q <= count_d;
               end
            end
            ST_HALT: begin
               if (bus.start) begin
                  state_q  <= ST_LOAD;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= ST_LOAD;
               running_q <= 1'b0;
               halted_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.instr       = (state_q == ST_RUN) ? fetched : NOP_WORD;
   assign bus.opcode      = bus.instr[31:26];
   assign bus.pc          = pc_q;
   assign bus.pc_plus4    = pc_plus4;
   assign bus.running     = running_q;
   assign bus.halted      = halted_q;
   assign bus.instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit: behavioural model
//                with per-cycle compare, directed literal cases and random
//                programs; a second 4-word instance covers the range limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

   localparam int          DEPTH = 64;
   localparam logic [31:0] HALTW = 32'hFFFF_FFFF;
   localparam int          MD_LOAD = 10;
   localparam int          MD_RUN  = 11;
   localparam int          MD_HALT = 12;

   logic clk;
   logic reset;

   instr_fetch_unit_if #(.ADDR_W(6)) ifc ();
   instr_fetch_unit_if #(.ADDR_W(2)) ifc2 ();

   instr_fetch_unit #(.IMEM_DEPTH(64), .ADDR_W(6), .RESET_PC(32'h0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   instr_fetch_unit #(.IMEM_DEPTH(4), .ADDR_W(2), .RESET_PC(32'h0)) dut_small (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc2)
   );

   int n_checks = 0;
   int n_err    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model of the 64-word unit ----------------
   int          m_mode;
   logic [31:0] m_pc;
   logic [31:0] m_cnt;
   logic [31:0] m_mem [DEPTH];

   function automatic logic [31:0] model_next_pc(input logic [31:0] pc,
                                                 input logic [31:0] w,
                                                 input logic take);
      int off;
      off = int'(signed'(w[15:0])) * 4;
      return take ? (pc + 32'd4 + 32'(off)) : (pc + 32'd4);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_mode <= MD_LOAD;
         m_pc   <= 32'h0;
         m_cnt  <= 32'h0;
      end else if (m_mode == MD_LOAD) begin
         if (ifc.load_en) m_mem[ifc.load_addr] <= ifc.load_data;
         if (ifc.start) begin
            m_mode <= MD_RUN;
            m_pc   <= 32'h0;
            m_cnt  <= 32'h0;
         end
      end else if (m_mode == MD_RUN) begin
         if (m_pc >= 32'(DEPTH * 4) || m_mem[m_pc[7:2]] == HALTW) begin
            m_mode <= MD_HALT;
         end else begin
            m_pc <= model_next_pc(m_pc, m_mem[m_pc[7:2]], ifc.branch & ifc.zero);
            if (m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
         end
      end else begin
         if (ifc.start) m_mode <= MD_LOAD;
      end
   end

   function automatic logic [31:0] exp_instr();
      if (m_mode == MD_RUN && m_pc < 32'(DEPTH * 4)) return m_mem[m_pc[7:2]];
      return 32'h0;
   endfunction

   // Per-cycle compare of every output of the 64-word unit against the model
   always @(negedge clk) begin
      logic [31:0] ei;
      ei = exp_instr();
      chk("instr",    ifc.instr,          ei);
      chk("opcode",   {26'b0, ifc.opcode}, {26'b0, ei[31:26]});
      chk("pc",       ifc.pc,             m_pc);
      chk("pc_plus4", ifc.pc_plus4,       m_pc + 32'd4);
      chk("running",  {31'b0, ifc.running}, {31'b0, m_mode == MD_RUN});
      chk("halted",   {31'b0, ifc.halted},  {31'b0, m_mode == MD_HALT});
      chk("count",    ifc.instr_count,    m_cnt);
   end

   // ---------------- stimulus helpers ----------------
   task automatic load_word(input int a, input logic [31:0] d, input logic with_start);
      ifc.load_en   = 1'b1;
      ifc.load_addr = 6'(a);
      ifc.load_data = d;
      ifc.start     = with_start;
      @(negedge clk);
      ifc.load_en = 1'b0;
      ifc.start   = 1'b0;
   endtask

   task automatic pulse_start();
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
   endtask

   task automatic quiet_inputs();
      ifc.load_en = 1'b0;
      ifc.start   = 1'b0;
      ifc.branch  = 1'b0;
      ifc.zero    = 1'b0;
   endtask

   task automatic sync_reset_pulse();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic async_reset_pulse();
      #($urandom_range(1, 3));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic [31:0] rand_word();
      int r;
      int imm;
      logic [5:0] op;
      r = int'($urandom_range(0, 11));
      if (r == 0) return HALTW;
      case (r % 4)
         0:       op = 6'b000000;
         1:       op = 6'b100011;
         2:       op = 6'b101011;
         default: op = 6'b000100;
      endcase
      imm = int'($urandom_range(0, 16)) - 8;
      return {op, 10'($urandom), 16'(imm)};
   endfunction

   task automatic random_run(input int budget);
      for (int c = 0; c < budget; c++) begin
         ifc.branch    = 1'($urandom);
         ifc.zero      = 1'($urandom);
         ifc.load_en   = 1'($urandom);
         ifc.load_addr = 6'($urandom);
         ifc.load_data = $urandom;
         ifc.start     = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         if (ifc.halted) break;
      end
      quiet_inputs();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      reset = 1'b1;
      ifc.load_addr = '0;
      ifc.load_data = '0;
      quiet_inputs();
      ifc2.load_en = 1'b0; ifc2.load_addr = '0; ifc2.load_data = '0;
      ifc2.start = 1'b0;   ifc2.branch = 1'b0;  ifc2.zero = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Idle after reset: nothing moves without start
      repeat (10) @(negedge clk);
      chk("idle_pc",      ifc.pc, 32'h0);
      chk("idle_instr",   ifc.instr, 32'h0);
      chk("idle_running", {31'b0, ifc.running}, 32'h0);
      chk("idle_halted",  {31'b0, ifc.halted}, 32'h0);

      for (int a = 0; a < DEPTH; a++) load_word(a, 32'h0, 1'b0);

      // lw, sw, halt marker
      load_word(0, 32'h8C01_0004, 1'b0);
      load_word(1, 32'hAC01_0008, 1'b0);
      load_word(2, HALTW, 1'b0);
      pulse_start();
      chk("lw_opcode", {26'b0, ifc.opcode}, 32'h23);
      @(negedge clk);
      chk("sw_opcode", {26'b0, ifc.opcode}, 32'h2B);
      repeat (2) @(negedge clk);
      chk("halt_flag",  {31'b0, ifc.halted}, 32'h1);
      chk("halt_pc",    ifc.pc, 32'h8);
      chk("halt_count", ifc.instr_count, 32'h2);
      chk("halt_instr", ifc.instr, 32'h0);
      pulse_start();
      chk("reload_running", {31'b0, ifc.running}, 32'h0);

      // Forward and backward taken branches
      load_word(0, 32'h1000_0002, 1'b0);
      load_word(3, 32'h1000_FFFD, 1'b0);
      ifc.branch = 1'b1;
      ifc.zero   = 1'b1;
      pulse_start();
      chk("br_pc0", ifc.pc, 32'h0);
      @(negedge clk);
      chk("br_fwd", ifc.pc, 32'hC);
      @(negedge clk);
      chk("br_back", ifc.pc, 32'h4);
      sync_reset_pulse();
      ifc.zero = 1'b0;
      pulse_start();
      @(negedge clk);
      chk("br_not_taken", ifc.pc, 32'h4);
      quiet_inputs();
      sync_reset_pulse();

      // Asynchronous reset mid-run at pc=8, then rerun the retained program
      pulse_start();
      repeat (2) @(negedge clk);
      chk("pre_reset_pc", ifc.pc, 32'h8);
      #2 reset = 1'b1;
      #1;
      chk("async_pc",      ifc.pc, 32'h0);
      chk("async_running", {31'b0, ifc.running}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      pulse_start();
      chk("rerun_opcode", {26'b0, ifc.opcode}, 32'h04);
      for (int c = 0; c < 20 && !ifc.halted; c++) @(negedge clk);
      chk("rerun_halted", {31'b0, ifc.halted}, 32'h1);
      chk("rerun_count",  ifc.instr_count, 32'h2);
      pulse_start();

      // Random programs against the model
      for (int it = 0; it < 8; it++) begin
         for (int a = 0; a < DEPTH; a++)
            load_word(a, rand_word(), (a == DEPTH - 1) && (it % 2 == 1));
         if (it % 2 == 0) pulse_start();
         random_run(250);
         if (ifc.halted) begin
            pulse_start();
            pulse_start();
            random_run(100);
         end
         if (ifc.halted) pulse_start();
         else async_reset_pulse();
      end

      // 4-word instance: all NOPs run off the end of memory
      for (int a = 0; a < 4; a++) begin
         ifc2.load_en = 1'b1; ifc2.load_addr = 2'(a); ifc2.load_data = 32'h0;
         @(negedge clk);
      end
      ifc2.load_en = 1'b0;
      ifc2.start = 1'b1;
      @(negedge clk);
      ifc2.start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("oor_pc", ifc2.pc, 32'(k * 4));
         if (k < 4) @(negedge clk);
      end
      chk("oor_instr",   ifc2.instr, 32'h0);
      chk("oor_running", {31'b0, ifc2.running}, 32'h1);
      @(negedge clk);
      chk("oor_halted",  {31'b0, ifc2.halted}, 32'h1);
      chk("oor_pc_hold", ifc2.pc, 32'h10);
      chk("oor_count",   ifc2.instr_count, 32'h4);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
